// File: rtl/fp_pkg.sv
// Shared widths, FSM states and result record for the post-divide normalizer.
package fp_pkg;

    localparam int MAN_W   = 24;
    localparam int EXP_W   = 10;
    localparam int SHAMT_W = 5;
    localparam logic signed [EXP_W-1:0] EXP_MIN = 10'sd1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic [MAN_W-1:0]   man;
        logic [EXP_W-1:0]   exp;
        logic               sign;
        logic [SHAMT_W-1:0] shamt;
        logic               denorm;
        logic               zero;
    } result_t;

endpackage

// File: rtl/fp_lzc_step.sv
// Leading-zero count over a STEP-bit window; all-zero window reports STEP.
// Purely combinational, no handshake.
// Backpressure: none, pure function of its input.
module fp_lzc_step #(
    parameter int STEP = 4,
    localparam int CW  = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] field,
    output logic [CW-1:0]   cnt
);

    logic found;

    always_comb begin
        cnt   = CW'(STEP);
        found = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (!found && field[i]) begin
                cnt   = CW'(STEP - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_norm_seq.sv
// Post-divide normalizer: shifts the quotient mantissa left up to STEP bits/cycle until bit 23 is set or exp hits 1.
// Latency: ceil(lz/STEP)+2 cycles from accept (zero mantissa: 1); one operand in flight at a time.
// Backpressure: result held in DONE with outputs frozen until out_ready; in_ready low outside IDLE.
module fp_div_norm_seq
    import fp_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W-1:0]   in_man,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic               in_sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W-1:0]   out_man,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_sign,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_denorm,
    output logic               out_zero
);

    localparam int CW = $clog2(STEP + 1);

    state_t  state_q, state_d;
    result_t res_q, res_d;

    logic [CW-1:0]      lz;
    logic [EXP_W-1:0]   k_ext;
    logic [EXP_W-1:0]   limit;
    logic [SHAMT_W-1:0] s;

    fp_lzc_step #(.STEP(STEP)) u_lzc (
        .field (res_q.man[MAN_W-1 -: STEP]),
        .cnt   (lz)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        k_ext   = EXP_W'(lz);
        // Only consulted when exp > EXP_MIN, so limit is always positive here.
        limit   = res_q.exp - EXP_W'(1);
        s       = (k_ext < limit) ? k_ext[SHAMT_W-1:0] : limit[SHAMT_W-1:0];

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    res_d.sign   = in_sign;
                    res_d.shamt  = '0;
                    res_d.denorm = 1'b0;
                    if (in_man == '0) begin
                        res_d.man  = '0;
                        res_d.exp  = '0;
                        res_d.zero = 1'b1;
                        state_d    = DONE;
                    end else begin
                        res_d.man  = in_man;
                        res_d.exp  = in_exp;
                        res_d.zero = 1'b0;
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (res_q.man[MAN_W-1] || ($signed(res_q.exp) <= EXP_MIN)) begin
                    res_d.denorm = ~res_q.man[MAN_W-1] & ~res_q.zero;
                    state_d      = DONE;
                end else begin
                    res_d.man   = res_q.man << s;
                    res_d.exp   = res_q.exp - EXP_W'(s);
                    res_d.shamt = res_q.shamt + s;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign in_ready   = (state_q == IDLE) & ~rst;
    assign out_valid  = (state_q == DONE);
    assign out_man    = res_q.man;
    assign out_exp    = res_q.exp;
    assign out_sign   = res_q.sign;
    assign out_shamt  = res_q.shamt;
    assign out_denorm = res_q.denorm;
    assign out_zero   = res_q.zero;

endmodule

// File: doc/fp_div_norm_seq.md
# fp_div_norm_seq

Sequential post-divide normalizer for the FPU divider datapath. It takes the raw 24-bit quotient mantissa, the biased exponent and the sign, and left-shifts the mantissa until the hidden bit (bit 23) is set. Each shift decrements the exponent. Shifting stops at the minimum normal exponent, which yields a denormal result. The block consumes leading-zero information internally, STEP bits per cycle, and sits between the divider core and the rounding stage with valid/ready handshakes on both sides.

## Interface
- STEP, 4: maximum left-shift per cycle. Legal values 1, 2, 4, 8.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_man  in  24  unnormalized quotient mantissa.
- in_exp  in  10  biased exponent, two's complement.
- in_sign  in  1  sign, passed through.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- out_man  out  24  normalized (or denormal) mantissa.
- out_exp  out  10  adjusted exponent.
- out_sign  out  1  registered in_sign.
- out_shamt  out  5  total left shift applied.
- out_denorm  out  1  result has bit 23 clear and a nonzero mantissa.
- out_zero  out  1  in_man was zero.

## Operation
- There are three states: IDLE, SHIFT and DONE.
- **IDLE**
  - in_ready is 1.
  - On in_valid & in_ready, the block registers man, exp and sign, and clears shamt.
  - If in_man == 0, it moves to DONE with man = 0, exp = 0 and zero = 1.
  - Otherwise it moves to SHIFT.
- **SHIFT**, evaluated once per cycle:
  - If man[23] == 1 or exp <= EXP_MIN (1), the block moves to DONE with no shift.
  - Otherwise, k = leading zeros within man[23:24-STEP], with k = STEP when that field is all zero.
  - limit = exp - 1, and s = min(k, limit).
  - Update: man <<= s, exp -= s, shamt += s.
  - The block stays in SHIFT.
- **DONE**
  - out_valid is 1.
  - out_denorm = ~man[23] & ~zero.
  - All outputs are held stable until out_ready is seen.
  - When out_valid & out_ready, the block returns to IDLE.
- in_exp <= 1 at entry means no shift is ever applied. The mantissa passes through unchanged; out_denorm is set if bit 23 is clear.
- Arithmetic rules:
  - shamt saturates naturally, because the maximum total shift is 23.
  - The exponent subtraction is 10-bit two's complement. Because of the limit, it never goes below 1.
- Zero-filled bits enter at the LSB.

## Timing
- While rst is high, the block is forced to IDLE. All outputs are registered or state-decoded and read 0, including in_ready = 0.
- From the first cycle after rst deasserts, in_ready is 1.
- rst asserted in any state aborts the operation. The next cycle is IDLE, and no out_valid is produced for the aborted operand.
- Latency for a nonzero mantissa with lz leading zeros and no exponent clamp: out_valid rises ceil(lz/STEP) + 2 cycles after the accepting edge.
- Latency for a zero mantissa: out_valid rises 1 cycle after acceptance.
- Clamped case: the number of SHIFT cycles is ceil(applied/STEP) + 1.
- in_ready is 0 in SHIFT and DONE. Back-to-back throughput is therefore one operand per (latency + 1) cycles.
- Simultaneous out_valid & out_ready and new in_valid: the new operand is not accepted in that cycle. It can be accepted in the following IDLE cycle.
- Backpressure: DONE may last any number of cycles, with outputs frozen throughout.

## Structure
- Package fp_pkg holds:
  - MAN_W = 24, EXP_W = 10, EXP_MIN = 1.
  - The state enum {IDLE, SHIFT, DONE}.
  - The result struct {man, exp, sign, shamt, denorm, zero}.
- Sub-module fp_lzc_step:
  - Combinational leading-zero count over the top STEP bits.
  - Output width $clog2(STEP+1).
  - Instantiated once.
- Everything else belongs in a single always_ff / next-state block.

## Test plan
- in_man=0x000001, in_exp=100, STEP=4 → out_man=0x800000, out_exp=77, out_shamt=23, denorm=0; out_valid 8 cycles after accept.
- in_man=0x0C0000, in_exp=10 → out_man=0xC00000, out_exp=6, out_shamt=4; out_valid 3 cycles after accept.
- in_man=0x001000, in_exp=5 (clamp) → out_man=0x010000, out_exp=1, out_shamt=4, out_denorm=1; out_valid 3 cycles after accept.
- in_man=0x000000, in_exp=50, in_sign=1 → out_man=0, out_exp=0, out_zero=1, out_sign=1; out_valid 1 cycle after accept.
- in_man=0x800000, in_exp=0 → passthrough: out_shamt=0, out_exp=0, denorm=0; out_valid 2 cycles after accept. Then hold out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout.
- Assert rst while in SHIFT on operand 0x000001 → next cycle is IDLE with out_valid=0. A following operand 0x400000, exp=3 → out_man=0x800000, exp=2, shamt=1.
